// File: rtl/uart_tx_frame.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// uart_tx_frame
//   UART transmitter with an internal baud divider. Accepts one data word per
//   valid/ready handshake and sends it LSB-first as a frame: start bit, data
//   bits, optional parity bit, stop bits. The serial line idles high.
//
//   Optional feature macro: UART_TX_PARITY_EN
//     defined   -> a parity bit (^data ^ parity_odd) follows the last data bit
//     undefined -> no parity bit; parity_odd is ignored
//
// Parameters
//   DATA_BITS     data bits per frame (5..9)
//   STOP_BITS     stop bits per frame (1..2)
//   CLKS_PER_BIT  clk cycles per bit period (>= 1)
//
// Ports
//   clk         system clock, all logic on posedge
//   rst_n       asynchronous active-low reset
//   tx_valid    tx_data holds a word to send
//   tx_ready    idle and able to accept; transfer on posedge with valid && ready
//   tx_data     word to send, sampled only on the transfer edge
//   parity_odd  1 = odd parity, 0 = even, sampled on the transfer edge
//   tx_busy     a frame is in progress
//   tx_done     one-cycle pulse at the edge that completes the last stop bit
//   tx          registered serial output
// -----------------------------------------------------------------------------
module uart_tx_frame #(
  parameter int DATA_BITS    = 8,
  parameter int STOP_BITS    = 1,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 parity_odd,
  output logic                 tx_busy,
  output logic                 tx_done,
  output logic                 tx
);

  // ---------------------------------------------------------------------------
  // Parameter legality
  // ---------------------------------------------------------------------------
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_tx_frame: DATA_BITS=%0d is outside 5..9", DATA_BITS);
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
    $error("uart_tx_frame: STOP_BITS=%0d is outside 1..2", STOP_BITS);
  end
  if (CLKS_PER_BIT < 1) begin : g_bad_clks_per_bit
    $error("uart_tx_frame: CLKS_PER_BIT=%0d must be >= 1", CLKS_PER_BIT);
  end

  localparam int                CNT_W     = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam int                BIT_W     = 4;  // covers up to 9 data bits
  localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t               state;
  state_t               state_next;
  logic [CNT_W-1:0]     div_cnt;
  logic [BIT_W-1:0]     bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 bit_end;
  logic                 last_data;
  logic                 last_stop;

  // A bit period ends on the CLKS_PER_BIT-th cycle after it began. With
  // CLKS_PER_BIT=1 the divider is permanently 0, so every cycle is a boundary.
  assign bit_end   = (state != IDLE) && (div_cnt == CNT_LAST);
  assign last_data = (bit_cnt == DATA_LAST);
  assign last_stop = (bit_cnt == STOP_LAST);

`ifdef UART_TX_PARITY_EN
  logic par_bit;
`else
  logic unused_parity_odd;
  assign unused_parity_odd = parity_odd;
`endif

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: clocked blocks use non-blocking assignments so every register
  // updates from pre-edge values, independent of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: default assignment first, so every path drives state_next and no
  // latch is inferred.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:   if (tx_valid) state_next = START;
      START:  if (bit_end) state_next = DATA;
`ifdef UART_TX_PARITY_EN
      DATA:   if (bit_end && last_data) state_next = PARITY;
      PARITY: if (bit_end) state_next = STOP;
`else
      DATA:   if (bit_end && last_data) state_next = STOP;
`endif
      STOP:   if (bit_end && last_stop) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs decoded from state
  // ---------------------------------------------------------------------------
  always_comb begin
    tx_ready = (state == IDLE);
    tx_busy  = (state != IDLE);
  end

  // ---------------------------------------------------------------------------
  // Datapath: divider, bit counter, shift register, registered line and done
  // ---------------------------------------------------------------------------
  // NOTE: the shift register is reset along with the control state; it is a
  // handful of flops and this keeps it free of X after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      tx      <= 1'b1;
      tx_done <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_bit <= 1'b0;
`endif
    end else begin
      tx_done <= 1'b0;

      // Divider restarts at the transfer and at every bit boundary.
      if (state == IDLE || bit_end) div_cnt <= '0;
      else                          div_cnt <= div_cnt + CNT_W'(1);

      case (state)
        IDLE: begin
          if (tx_valid) begin
            shreg   <= tx_data;
            bit_cnt <= '0;
            tx      <= 1'b0;  // start bit begins at the transfer edge
`ifdef UART_TX_PARITY_EN
            par_bit <= (^tx_data) ^ parity_odd;
`endif
          end
        end

        START: begin
          if (bit_end) begin
            tx    <= shreg[0];
            shreg <= shreg >> 1;
          end
        end

        DATA: begin
          if (bit_end) begin
            if (last_data) begin
              bit_cnt <= '0;  // reused to count stop bits
`ifdef UART_TX_PARITY_EN
              tx      <= par_bit;
`else
              tx      <= 1'b1;
`endif
            end else begin
              bit_cnt <= bit_cnt + BIT_W'(1);
              tx      <= shreg[0];
              shreg   <= shreg >> 1;
            end
          end
        end

`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (bit_end) tx <= 1'b1;
        end
`endif

        STOP: begin
          if (bit_end) begin
            if (last_stop) tx_done <= 1'b1;  // line stays high into IDLE
            else           bit_cnt <= bit_cnt + BIT_W'(1);
          end
        end

        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_uart_tx_frame
//   Two instances: u0 (8 data, 1 stop, 4 clks/bit) and u1 (5 data, 2 stop,
//   1 clk/bit). Expected frames for u0 are queued when a transfer is driven and
//   popped by a line monitor when a start bit appears; the monitor checks the
//   level of every cycle of the frame plus the tx_done slot.
// -----------------------------------------------------------------------------
module tb_uart_tx_frame;

`ifdef UART_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif

  localparam int C0 = 4;
  localparam int F0 = 1 + 8 + P + 1;
  localparam int C1 = 1;
  localparam int F1 = 1 + 5 + P + 2;

  logic       clk = 1'b0;
  logic       rst_n;
  // u0
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       parity_odd;
  logic       tx_ready0, tx_busy0, tx_done0, tx0;
  // u1
  logic       v1;
  logic [4:0] d1;
  logic       po1;
  logic       tx_ready1, tx_busy1, tx_done1, tx1;

  always #5 clk = ~clk;

  uart_tx_frame #(.DATA_BITS(8), .STOP_BITS(1), .CLKS_PER_BIT(C0)) u0 (
    .clk(clk), .rst_n(rst_n), .tx_valid(tx_valid), .tx_ready(tx_ready0),
    .tx_data(tx_data), .parity_odd(parity_odd), .tx_busy(tx_busy0),
    .tx_done(tx_done0), .tx(tx0)
  );

  uart_tx_frame #(.DATA_BITS(5), .STOP_BITS(2), .CLKS_PER_BIT(C1)) u1 (
    .clk(clk), .rst_n(rst_n), .tx_valid(v1), .tx_ready(tx_ready1),
    .tx_data(d1), .parity_odd(po1), .tx_busy(tx_busy1),
    .tx_done(tx_done1), .tx(tx1)
  );

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", tag, got, want, $time);
    end
  endtask

  // Frame bit i is the line level during bit period i; bit 0 is the start bit.
  // Bits beyond the data (and parity) are stop/idle, i.e. 1.
  function automatic logic [15:0] build_frame(input logic [8:0] d, input int nd, input logic po);
    logic [15:0] f;
    logic        p;
    f    = '1;
    f[0] = 1'b0;
    p    = po;
    for (int i = 0; i < nd; i++) begin
      f[1+i] = d[i];
      p      = p ^ d[i];
    end
    if (P == 1) f[1+nd] = p;
    return f;
  endfunction

  // ---------------------------------------------------------------------------
  // u0 line monitor / scoreboard consumer
  // ---------------------------------------------------------------------------
  logic [15:0] exp_q[$];
  logic [15:0] exp_f, obs_f;
  bit          in_frame = 1'b0;
  int          idx, bad_cycles, spurious_done;
  int          cyc = 0, last_start = 0, prev_start = 0;

  initial spurious_done = 0;

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      in_frame = 1'b0;
      if (tx_done0) spurious_done++;
    end else begin
      if (!in_frame) begin
        if (tx_done0) spurious_done++;
        if (tx0 == 1'b0) begin
          if (exp_q.size() == 0) begin
            check("unexpected_start", tx0, 1);
          end else begin
            exp_f      = exp_q.pop_front();
            obs_f      = '1;
            in_frame   = 1'b1;
            idx        = 0;
            bad_cycles = 0;
            prev_start = last_start;
            last_start = cyc;
          end
        end
      end
      if (in_frame) begin
        if (idx < F0*C0) begin
          if (tx0 !== exp_f[idx/C0] || tx_done0 || !tx_busy0 || tx_ready0) bad_cycles++;
          if (idx % C0 == C0/2) obs_f[idx/C0] = tx0;
          idx++;
        end else begin
          check("frame_bits", obs_f, exp_f);
          check("bit_hold", bad_cycles, 0);
          check("done_slot", {tx_done0, tx_busy0, tx_ready0, tx0}, 4'b1011);
          in_frame = 1'b0;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Drivers
  // ---------------------------------------------------------------------------
  // Called at a negedge; returns at the negedge after the transfer edge.
  task automatic send0(input logic [7:0] d, input logic po, input bit keep);
    int n = 0;
    tx_valid   = 1'b1;
    tx_data    = d;
    parity_odd = po;
    while (!tx_ready0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (!tx_ready0) begin
      check("ready_timeout", tx_ready0, 1);
      tx_valid = 1'b0;
      return;
    end
    exp_q.push_back(build_frame({1'b0, d}, 8, po));
    @(posedge clk);
    @(negedge clk);
    tx_data    = 8'($urandom);  // must not disturb the frame in flight
    parity_odd = 1'($urandom);
    if (!keep) tx_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((exp_q.size() != 0 || in_frame) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", (exp_q.size() == 0 && !in_frame), 1);
  endtask

  task automatic frame1(input logic [4:0] d, input logic po);
    logic [15:0] want, obs;
    int          early;
    want  = build_frame({4'b0, d}, 5, po);
    obs   = '1;
    early = 0;
    check("u1_ready", tx_ready1, 1);
    v1  = 1'b1;
    d1  = d;
    po1 = po;
    @(posedge clk);
    @(negedge clk);
    v1 = 1'b0;
    d1 = ~d;
    for (int i = 0; i < F1*C1; i++) begin
      obs[i] = tx1;
      if (tx_done1 || !tx_busy1) early++;
      @(negedge clk);
    end
    check("u1_frame", obs, want);
    check("u1_busy_no_early_done", early, 0);
    check("u1_done_slot", {tx_done1, tx_busy1, tx_ready1, tx1}, 4'b1011);
    @(negedge clk);
    check("u1_done_width", tx_done1, 0);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    rst_n      = 1'b0;
    tx_valid   = 1'b0;
    tx_data    = '0;
    parity_odd = 1'b0;
    v1         = 1'b0;
    d1         = '0;
    po1        = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_u0", {tx_done0, tx_busy0, tx_ready0, tx0}, 4'b0011);
    check("rst_u1", {tx_done1, tx_busy1, tx_ready1, tx1}, 4'b0011);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 0xA5 frame, exact bit timing and tx_done slot.
    send0(8'hA5, 1'b0, 1'b0);
    wait_idle();

    // Both parity senses on the same payload.
    send0(8'hA5, 1'b0, 1'b0);
    wait_idle();
    send0(8'hA5, 1'b1, 1'b0);
    wait_idle();

    // tx_valid pulse between edges: no transfer.
    #1 tx_valid = 1'b1;
    tx_data = 8'h5A;
    #2 tx_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("valid_glitch_idle", {tx_busy0, tx_ready0, tx0}, 3'b011);

    // Back-to-back with tx_valid held; data changes mid-frame.
    send0(8'h00, 1'b0, 1'b1);
    send0(8'hFF, 1'b0, 1'b0);
    wait_idle();
    check("b2b_spacing", last_start - prev_start, F0*C0 + 1);

    // Reset during data bit 3 (0xA5 bit 3 is 0, so tx visibly rises).
    send0(8'hA5, 1'b0, 1'b0);
    repeat (4*C0) @(negedge clk);
    #1 rst_n = 1'b0;
    #1 check("rst_mid_frame", {tx_done0, tx_busy0, tx_ready0, tx0}, 4'b0011);
    @(negedge clk);
    #1 rst_n = 1'b1;
    exp_q.delete();
    @(negedge clk);
    check("post_rst_ready", tx_ready0, 1);
    send0(8'h3C, 1'b1, 1'b0);
    wait_idle();

    // Narrow, two-stop, one-clock-per-bit instance.
    frame1(5'h13, 1'b0);
    frame1(5'h13, 1'b1);
    for (int i = 0; i < 8; i++) frame1(5'($urandom), 1'($urandom));

    // Randomised payloads, parity sense, gaps and back-to-back runs.
    for (int i = 0; i < 1000; i++) begin
      bit keep;
      keep = (i < 999) && ($urandom_range(0, 3) == 0);
      send0(8'($urandom), 1'($urandom), keep);
      if (!keep) repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    wait_idle();
    repeat (3) @(negedge clk);
    check("spurious_done", spurious_done, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
